// File: rtl/rr_enc_arbiter_pkg.sv
// Shared types and sizes for the round-robin encoded arbiter.
//   N     : number of requesters (fixed at 8)
//   IDXW  : width of an encoded requester index (log2 N)
//   req_vec_t / idx_t : request-vector and index types
//   state_t           : arbiter FSM states
package arb_pkg;

  localparam int unsigned N    = 8;
  localparam int unsigned IDXW = 3;

  typedef logic [N-1:0]    req_vec_t;
  typedef logic [IDXW-1:0] idx_t;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

endpackage

// File: rtl/rr_enc_arbiter_pick.sv
// rr_pick: combinational rotating-priority picker.
// Finds the first set bit of req searching ptr, ptr+1, ... wrapping N-1 to 0.
// Ports:
//   req      in  request vector
//   ptr      in  highest-priority index
//   pick     out one-hot selection (zero when nothing requested)
//   pick_idx out encoded selection (valid when any=1)
//   any      out at least one request present
module rr_pick
  import arb_pkg::*;
(
  input  req_vec_t req,
  input  idx_t     ptr,
  output req_vec_t pick,
  output idx_t     pick_idx,
  output logic     any
);

  req_vec_t rot;
  idx_t     off;
  idx_t     src;

  // Rotate so ptr lands at bit 0, priority-encode the lowest set bit,
  // then add ptr back; IDXW-bit addition wraps modulo N.
  always_comb begin
    rot = '0;
    src = '0;
    for (int unsigned i = 0; i < N; i++) begin
      src    = idx_t'(i) + ptr;
      rot[i] = req[src];
    end

    any = |rot;

    off = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) off = idx_t'(i - 1);
    end

    pick_idx = ptr + off;
    pick     = '0;
    if (any) pick[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_enc_arbiter.sv
// rr_enc_arbiter: 8-way round-robin arbiter with registered one-hot grant
// and encoded grant index. A grant is held until its owner drops req; on
// release the pointer moves past the owner and the remaining requests are
// arbitrated in the same edge (no idle bubble).
// Optional feature macro: ARB_TIMEOUT_EN adds parameter TMO_CYC and the tmo
// output; a grant held for TMO_CYC cycles is forcibly released.
// Ports:
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset
//   req      in  request vector
//   gnt      out registered one-hot grant
//   gnt_idx  out registered encoded grant index (holds last value when idle)
//   gnt_vld  out high while a grant is held
//   tmo      out one-cycle pulse on forced release (ARB_TIMEOUT_EN only)
module rr_enc_arbiter
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned TMO_CYC = 16
)
`endif
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld
`ifdef ARB_TIMEOUT_EN
  ,
  output logic            tmo
`endif
);

  state_t   state_q, state_n;
  idx_t     ptr_q, ptr_n;
  req_vec_t gnt_q, gnt_n;
  idx_t     idx_q, idx_n;
  logic     vld_q, vld_n;

  logic     owner_req;
  logic     forced;
  logic     rel;
  idx_t     rel_ptr;
  req_vec_t pick_req;
  idx_t     pick_ptr;
  req_vec_t pick;
  idx_t     pick_idx;
  logic     pick_any;
  logic     new_gnt;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TMO_CYC) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             tmo_q, tmo_n;
`endif

  rr_pick u_pick (
    .req      (pick_req),
    .ptr      (pick_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // Picker operands: in IDLE search from ptr; on release search from the
  // slot after the owner. On a forced release the owner's still-high bit is
  // masked so it cannot be re-granted in the same edge.
  always_comb begin
    owner_req = |(req & gnt_q);
    forced    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    forced    = (state_q == GRANT) && owner_req &&
                (cnt_q == CNT_W'(TMO_CYC - 1));
`endif
    rel       = (state_q == GRANT) && (!owner_req || forced);
    rel_ptr   = idx_q + idx_t'(1);
    pick_ptr  = (state_q == GRANT) ? rel_ptr : ptr_q;
    pick_req  = forced ? (req & ~gnt_q) : req;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      gnt_q   <= gnt_n;
      idx_q   <= idx_n;
      vld_q   <= vld_n;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_n;
      tmo_q   <= tmo_n;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    gnt_n   = gnt_q;
    idx_n   = idx_q;
    vld_n   = vld_q;
    new_gnt = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_n = GRANT;
          gnt_n   = pick;
          idx_n   = pick_idx;
          vld_n   = 1'b1;
          new_gnt = 1'b1;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_n = rel_ptr;
          if (pick_any) begin
            gnt_n   = pick;
            idx_n   = pick_idx;
            new_gnt = 1'b1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            vld_n   = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    if (new_gnt)                cnt_n = '0;
    else if (state_q == GRANT)  cnt_n = cnt_q + CNT_W'(1);
    else                        cnt_n = cnt_q;
    tmo_n = forced;
`endif
  end

  // Outputs come straight from flops
  always_comb begin
    gnt     = gnt_q;
    gnt_idx = idx_q;
    gnt_vld = vld_q;
`ifdef ARB_TIMEOUT_EN
    tmo     = tmo_q;
`endif
  end

endmodule

// File: tb/tb_rr_enc_arbiter.sv
module tb_rr_enc_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
`ifdef ARB_TIMEOUT_EN
  localparam int TMO = 4;
  logic       tmo;
`endif

`ifdef ARB_TIMEOUT_EN
  rr_enc_arbiter #(.TMO_CYC(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .tmo     (tmo)
  );
`else
  rr_enc_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       tmo;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner number (-1 = none), priority pointer, last index
  int m_owner;
  int m_ptr;
  int m_last;
  int m_hold;
  bit m_tmo;

  function automatic int arb(input logic [7:0] r, input int p);
    int j;
    for (int k = 0; k < 8; k++) begin
      j = (p + k) % 8;
      if (r[j[2:0]]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_last  = 0;
    m_hold  = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    bit         frc;
    logic [7:0] rr;
    int         w;
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      w = arb(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_hold  = 0;
      end
    end else begin
      frc = 1'b0;
`ifdef ARB_TIMEOUT_EN
      frc = r[m_owner[2:0]] && (m_hold == TMO - 1);
`endif
      if (!r[m_owner[2:0]] || frc) begin
        m_ptr = (m_owner + 1) % 8;
        rr = r;
        if (frc) rr[m_owner[2:0]] = 1'b0;
        w = arb(rr, m_ptr);
        m_owner = w;
        if (w >= 0) begin
          m_last = w;
          m_hold = 0;
        end
        m_tmo = frc;
      end else begin
        m_hold++;
      end
    end
  endtask

  // Apply req for the next edge and queue the response expected after it
  task automatic drive(input logic [7:0] v);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    req   = v;
    model_step(v);
    e.gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    e.idx = m_last[2:0];
    e.vld = (m_owner >= 0);
    e.tmo = m_tmo;
    sb.push_back(e);
  endtask

  // Reset asserted between edges must clear outputs without a clock
  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_gnt", {24'h0, gnt}, 32'h0);
    check("rst_vld", {31'h0, gnt_vld}, 32'h0);
    check("rst_idx", {29'h0, gnt_idx}, 32'h0);
`ifdef ARB_TIMEOUT_EN
    check("rst_tmo", {31'h0, tmo}, 32'h0);
`endif
    model_reset();
    req = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops one expectation per clock once stimulus is running
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("gnt", {24'h0, gnt}, {24'h0, e.gnt});
        check("gnt_idx", {29'h0, gnt_idx}, {29'h0, e.idx});
        check("gnt_vld", {31'h0, gnt_vld}, {31'h0, e.vld});
`ifdef ARB_TIMEOUT_EN
        check("tmo", {31'h0, tmo}, {31'h0, e.tmo});
`endif
        check("onehot0", {31'h0, $onehot0(gnt)}, 32'h1);
        check("vld_eq_any", {31'h0, gnt_vld}, {31'h0, (gnt != 8'h00)});
      end
    end
  end

  initial begin
    logic [7:0] v;
    logic [7:0] cur;

    model_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (3) @(posedge clk);

    // Rotation from reset: each owner drops its bit after two grant cycles
    for (int i = 0; i < 20; i++) begin
      v = 8'hFF;
      if (m_owner >= 0 && m_hold == 1) v[m_owner[2:0]] = 1'b0;
      drive(v);
    end
    drive(8'hFF);
    mid_reset();

    // Single request: ptr ends at 6
    repeat (4) drive(8'h20);
    repeat (2) drive(8'h00);

    // Wrap with skip from ptr=6
    repeat (3) drive(8'h09);
    repeat (3) drive(8'h08);
    repeat (2) drive(8'h00);

    // Starvation: 2 re-requests at once, 4 must win first
    repeat (2) drive(8'h04);
    repeat (2) drive(8'h14);
    drive(8'h10);
    repeat (3) drive(8'h14);
    repeat (2) drive(8'h04);
    repeat (2) drive(8'h00);

    // Long hold of requester 1 with 3 waiting
    drive(8'h02);
    repeat (100) drive(8'h0A);
    repeat (2) drive(8'h00);

    // Random traffic with slowly changing requests
    cur = 8'h00;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 4) == 0) cur[b] = ~cur[b];
      drive(cur);
      if (i == 200) begin
        mid_reset();
        cur = 8'h00;
      end
    end
    repeat (2) drive(8'h00);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_enc_arbiter.md
Name: rr_enc_arbiter

Overview:
- Round-robin arbiter that shares the 8-input priority encoder datapath between 8 requesters.
- Grants exactly one requester at a time and holds the grant until that requester releases.
- Outputs a one-hot grant and its 3-bit encoded index, so downstream muxing and encoding logic sees a stable, registered selection.
- Rotating priority guarantees no requester starves.

Parameters:
- N, 8: number of requesters; fixed at 8 for this revision.
- IDXW, 3: width of the encoded grant index, equal to log2(N).
- TMO_CYC, 16: maximum grant hold in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N  request vector; bit i means requester i wants the resource.
- gnt  out  N  registered one-hot grant.
- gnt_idx  out  IDXW  registered binary index of the granted requester.
- gnt_vld  out  1  high while any grant is held.
- tmo  out  1  one-cycle pulse on forced release; present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset: rst_n=0 clears immediately, without waiting for clk. Values: gnt=0, gnt_idx=0, gnt_vld=0, tmo=0, ptr=0, state=IDLE. This applies mid-grant as well; no grant survives reset.
- ptr (IDXW bits) is the highest-priority requester. Search order is ptr, ptr+1, ..., wrapping 7 to 0.
- States: IDLE and GRANT.
- IDLE:
  - If req!=0, grant the first set bit in search order at the next edge.
  - gnt, gnt_idx and gnt_vld all update together at that edge.
  - Latency: req seen at edge k gives gnt high after edge k, i.e. 1 cycle.
  - Go to GRANT.
- GRANT, owner o:
  - While req[o]=1, hold gnt, gnt_idx and gnt_vld unchanged. Changes on other req bits are ignored.
  - On the edge where req[o]=0 (release), set ptr=(o+1) mod 8. Wrap: o=7 gives ptr=0.
  - At that same edge, arbitrate the remaining req using the new ptr. If any bit is set, grant it directly with no bubble and stay in GRANT. Otherwise clear gnt and gnt_vld and go to IDLE.
  - gnt_idx keeps its last value in IDLE.
- The released owner reasserting req on the very next cycle has the lowest priority.
- All outputs are registered flops; there is no combinational path from req to gnt.
- Invariants, always:
  - gnt is zero or one-hot.
  - gnt_vld = (gnt != 0).
  - gnt_idx equals the encoded value of gnt whenever gnt_vld=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter (clog2(TMO_CYC)+1 bits) clears on every new grant and increments each GRANT cycle.
  - When the counter reaches TMO_CYC-1 with req[o] still high, treat that edge as a release: ptr advances, the next requester is granted or the arbiter goes to IDLE, and tmo pulses high for one cycle.
  - A forced-off requester still holding req gets a fresh grant only after its rotation turn comes around.
- Undefined: no counter and no tmo port; a grant is held indefinitely.

Decomposition:
- Package arb_pkg holds:
  - localparams N and IDXW.
  - typedef req_vec_t (logic [N-1:0]).
  - typedef idx_t (logic [IDXW-1:0]).
  - typedef enum state_t {IDLE, GRANT}.
- Sub-module rr_pick: combinational.
  - Inputs: req_vec_t, idx_t ptr.
  - Outputs: one-hot pick, idx_t pick_idx, any.
  - Implemented as rotate, priority-encode, rotate back.
- The arbiter instantiates rr_pick once, for both IDLE and release arbitration.

Test Plan:
- Reset: rst_n=0 with req=8'hFF, then release at cycle 3. gnt=8'h01 and gnt_idx=0 one cycle later. Asserting rst_n=0 mid-grant clears gnt, gnt_vld and gnt_idx immediately, before the next clk edge.
- Single request: req=8'h20 held 4 cycles, then dropped. gnt=8'h20 and gnt_idx=5 from the cycle after req, held 4 cycles. gnt_vld falls at the release edge; ptr becomes 6.
- Rotation: req=8'hFF, each owner drops its bit for one cycle after 2 cycles of grant. Grants go 0,1,2,...,7,0 back-to-back with no idle cycle, and gnt_idx tracks them.
- Wrap with skip: ptr=6 and req=8'h09. Grant goes to 0, then 3 after 0 releases; it never goes to 6 or 7.
- Starvation check: requester 2 re-requests immediately after its release while req[4]=1. Grant goes to 4 before 2 again.
- ARB_TIMEOUT_EN, TMO_CYC=4: req[1] held forever and req[3]=1. gnt[1] lasts exactly 4 cycles, tmo pulses once, gnt switches to 3. Without the macro, gnt[1] is held for 100 cycles.
